// File: rtl/mult_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int PROD_W    = 2 * DEF_WIDTH;
  localparam int MULT_LAT  = 3;

  // Rows left after one 3:2 level: each full group of three becomes two, leftovers pass through.
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of 3:2 reduction levels needed to bring n operands down to a sum/carry pair.
  function automatic int csa_levels(input int n);
    int m;
    int k;
    m = n;
    k = 0;
    while (m > 2) begin
      m = csa_next(m);
      k++;
    end
    return k;
  endfunction

  function automatic int rows_at(input int n, input int lvl);
    int m;
    m = n;
    for (int k = 0; k < lvl; k++) m = csa_next(m);
    return m;
  endfunction

endpackage

// File: rtl/mult_pipe_csa_3to2.sv
// Combinational 3:2 compressor row; carry comes out pre-shifted by one bit.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/mult_pipe.sv
// Three-stage WIDTHxWIDTH signed/unsigned multiplier: magnitudes, carry-save tree, final add/sign/overflow.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int LVLS = csa_levels(WIDTH);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Unsigned WIDTH bits already hold |-2^(WIDTH-1)| exactly, so no extra magnitude bit is kept.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  // ---------------- S1: operands -> magnitudes
  logic               v1, s1_neg, s1_sgn;
  logic [WIDTH-1:0]   s1_ma, s1_mb;
  logic [TAG_W-1:0]   s1_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      s1_neg <= 1'b0;
      s1_sgn <= 1'b0;
      s1_ma  <= '0;
      s1_mb  <= '0;
      s1_tag <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_neg <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s1_sgn <= in_signed;
        s1_ma  <= mag_of(in_a, in_signed);
        s1_mb  <= mag_of(in_b, in_signed);
        s1_tag <= in_tag;
      end
    end
  end

  // ---------------- S2: partial products and carry-save tree
  logic [WIDTH-1:0][PW-1:0] pp;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = s1_mb[i] ? (PW'(s1_ma) << i) : '0;
  end

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int N  = rows_at(WIDTH, l);
    localparam int NN = rows_at(WIDTH, l + 1);
    localparam int G  = N / 3;
    logic [N-1:0][PW-1:0]  rows_in;
    logic [NN-1:0][PW-1:0] rows_out;

    if (l == 0) begin : g_src
      assign rows_in = pp;
    end else begin : g_src
      assign rows_in = g_lvl[l-1].rows_out;
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(PW)) u_csa (
        .a    (rows_in[3*g]),
        .b    (rows_in[3*g+1]),
        .c    (rows_in[3*g+2]),
        .sum  (rows_out[2*g]),
        .carry(rows_out[2*g+1])
      );
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign rows_out[2*G+r] = rows_in[3*G+r];
    end
  end

  logic               v2, s2_neg, s2_sgn;
  logic [PW-1:0]      s2_sum, s2_carry;
  logic [TAG_W-1:0]   s2_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2       <= 1'b0;
      s2_neg   <= 1'b0;
      s2_sgn   <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        s2_neg   <= s1_neg;
        s2_sgn   <= s1_sgn;
        s2_sum   <= g_lvl[LVLS-1].rows_out[0];
        s2_carry <= g_lvl[LVLS-1].rows_out[1];
        s2_tag   <= s1_tag;
      end
    end
  end

  // ---------------- S3: carry-propagate add, sign fix-up, overflow
  logic [PW-1:0] raw, prod;
  logic          ovf;

  always_comb begin
    raw  = s2_sum + s2_carry;
    // A zero magnitude keeps its plain encoding regardless of the operand signs.
    prod = (s2_neg && (|raw)) ? -raw : raw;
    if (s2_sgn) ovf = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
    else        ovf = |prod[PW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        out_prod <= prod;
        out_ovf  <= ovf;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule
